// File: rtl/oai21_sweep_checker.sv
// Clocked exhaustive sweep of a 3-input cell: drives {A,B1,B2} through 000..111,
// holds each vector for a settle window, samples ZN and checks it against EXP_TT.
module oai21_sweep_checker #(
  parameter logic [7:0]  EXP_TT = 8'h1F,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       zn_in,
  output logic [2:0] stim,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail_idx,
  output logic       first_fail_valid,
  output logic [7:0] obs_tt
);

  localparam int unsigned SETTLE_EFF  = (SETTLE == 0) ? 1 : SETTLE;
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] stim_n;
  logic       busy_n, done_n, pass_n, ffv_n;
  logic [3:0] fc_n;
  logic [2:0] ffi_n;
  logic [7:0] obs_n;
  logic       mismatch;

  // start is a single-cycle request with no ready: it is accepted only in IDLE
  // or DONE, and any start seen while busy is dropped without side effects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= 3'd0;
      cnt              <= 8'd0;
      stim             <= 3'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= 4'd0;
      first_fail_idx   <= 3'd0;
      first_fail_valid <= 1'b0;
      obs_tt           <= 8'h00;
    end else begin
      state            <= state_n;
      idx              <= idx_n;
      cnt              <= cnt_n;
      stim             <= stim_n;
      busy             <= busy_n;
      done             <= done_n;
      pass             <= pass_n;
      fail_count       <= fc_n;
      first_fail_idx   <= ffi_n;
      first_fail_valid <= ffv_n;
      obs_tt           <= obs_n;
    end
  end

  // Case inequality so an unknown ZN in simulation is reported as a failure.
  assign mismatch = (zn_in !== EXP_TT[idx]);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    stim_n  = stim;
    busy_n  = busy;
    done_n  = done;
    pass_n  = pass;
    fc_n    = fail_count;
    ffi_n   = first_fail_idx;
    ffv_n   = first_fail_valid;
    obs_n   = obs_tt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = APPLY;
          idx_n   = 3'd0;
          cnt_n   = 8'd0;
          stim_n  = 3'd0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          fc_n    = 4'd0;
          ffi_n   = 3'd0;
          ffv_n   = 1'b0;
          obs_n   = 8'h00;
        end
      end
      APPLY: begin
        stim_n = idx;
        if (cnt == SETTLE_LAST) state_n = SAMPLE;
        else                    cnt_n   = cnt + 8'd1;
      end
      SAMPLE: begin
        obs_n[idx] = zn_in;
        if (mismatch) begin
          fc_n = fail_count + 4'd1;
          if (!first_fail_valid) begin
            ffi_n = idx;
            ffv_n = 1'b1;
          end
        end
        if (idx == 3'd7) begin
          state_n = DONE;
          pass_n  = (fc_n == 4'd0);
          done_n  = 1'b1;
          busy_n  = 1'b0;
          stim_n  = 3'd0;
        end else begin
          state_n = APPLY;
          idx_n   = idx + 3'd1;
          cnt_n   = 8'd0;
          stim_n  = idx + 3'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oai21_sweep_checker.sv
// Bench for oai21_sweep_checker: two instances (SETTLE=2 and SETTLE=1) driven by a
// table-lookup cell model; results checked against whole-table expectations.
module tb_oai21_sweep_checker;

  localparam logic [7:0] EXP = 8'h1F;

  logic clk, rst_n, start, sel;
  logic [7:0] tbl;
  int vectors, miscompares;

  logic       start_a, zn_a, busy_a, done_a, pass_a, ffv_a;
  logic [2:0] stim_a, ffi_a;
  logic [3:0] fc_a;
  logic [7:0] obs_a;
  logic       start_b, zn_b, busy_b, done_b, pass_b, ffv_b;
  logic [2:0] stim_b, ffi_b;
  logic [3:0] fc_b;
  logic [7:0] obs_b;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign zn_a = tbl[stim_a];
  assign zn_b = tbl[stim_b];

  oai21_sweep_checker #(.EXP_TT(EXP), .SETTLE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .zn_in(zn_a), .stim(stim_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a),
    .first_fail_idx(ffi_a), .first_fail_valid(ffv_a), .obs_tt(obs_a));

  oai21_sweep_checker #(.EXP_TT(EXP), .SETTLE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .zn_in(zn_b), .stim(stim_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b),
    .first_fail_idx(ffi_b), .first_fail_valid(ffv_b), .obs_tt(obs_b));

  logic [2:0] stim_o, ffi_o;
  logic       busy_o, done_o, pass_o, ffv_o;
  logic [3:0] fc_o;
  logic [7:0] obs_o;
  assign stim_o = sel ? stim_b : stim_a;
  assign busy_o = sel ? busy_b : busy_a;
  assign done_o = sel ? done_b : done_a;
  assign pass_o = sel ? pass_b : pass_a;
  assign ffv_o  = sel ? ffv_b  : ffv_a;
  assign ffi_o  = sel ? ffi_b  : ffi_a;
  assign fc_o   = sel ? fc_b   : fc_a;
  assign obs_o  = sel ? obs_b  : obs_a;

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-table view of what a finished sweep must report.
  task automatic model(input logic [7:0] t, output int e_fc, output int e_ffi,
                       output int e_ffv);
    e_fc = 0; e_ffi = 0; e_ffv = 0;
    for (int i = 0; i < 8; i++) begin
      if (t[i] !== EXP[i]) begin
        if (e_ffv == 0) begin
          e_ffi = i;
          e_ffv = 1;
        end
        e_fc++;
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_stim"}, 32'(stim_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_pass"}, 32'(pass_o), 0);
    chk({tag, "_fc"},   32'(fc_o), 0);
    chk({tag, "_ffi"},  32'(ffi_o), 0);
    chk({tag, "_ffv"},  32'(ffv_o), 0);
    chk({tag, "_obs"},  32'(obs_o), 0);
  endtask

  // Driver: one full sweep with the cell behaving as table t; optional start re-pulse.
  task automatic run_sweep(input logic [7:0] t, input int repulse_at);
    int per, e_fc, e_ffi, e_ffv;
    per = sel ? 2 : 3;
    tbl = t;
    model(t, e_fc, e_ffi, e_ffv);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_obs_clr", 32'(obs_o), 0);
    chk("start_fc_clr",  32'(fc_o), 0);
    chk("start_ffv_clr", 32'(ffv_o), 0);
    chk("start_pass_clr", 32'(pass_o), 0);
    for (int c = 0; c < 8 * per; c++) begin
      chk("stim_step", 32'(stim_o), 32'(c / per));
      chk("busy_run",  32'(busy_o), 1);
      chk("done_run",  32'(done_o), 0);
      start = (c + 1 == repulse_at);
      tick();
    end
    start = 1'b0;
    chk("end_done", 32'(done_o), 1);
    chk("end_busy", 32'(busy_o), 0);
    chk("end_stim", 32'(stim_o), 0);
    chk("end_obs",  32'(obs_o), 32'(t));
    chk("end_fc",   32'(fc_o), 32'(e_fc));
    chk("end_ffi",  32'(ffi_o), 32'(e_ffi));
    chk("end_ffv",  32'(ffv_o), 32'(e_ffv));
    chk("end_pass", 32'(pass_o), (e_fc == 0) ? 32'd1 : 32'd0);
    tick();
    chk("hold_done", 32'(done_o), 1);
    chk("hold_obs",  32'(obs_o), 32'(t));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    sel = 1'b0;
    tbl = EXP;
    #12;
    chk_reset("rst_a");
    sel = 1'b1;
    #1;
    chk_reset("rst_b");
    sel = 1'b0;
    rst_n = 1'b1;
    tick();

    run_sweep(8'h1F, -1);
    run_sweep(8'hFF, -1);
    run_sweep(8'h07, -1);
    run_sweep(8'h1F, 10);
    run_sweep(8'b1x01_1111, -1);
    for (int k = 0; k < 4; k++)
      run_sweep(8'($urandom), int'($urandom_range(1, 23)));

    // Asynchronous reset in the middle of vector 4.
    tbl = 8'h1F;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("pre_rst_stim", 32'(stim_o), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", 32'(busy_o), 0);
    chk("post_rst_done", 32'(done_o), 0);
    run_sweep(8'h1F, -1);

    sel = 1'b1;
    #1;
    run_sweep(8'h1F, -1);
    run_sweep(8'h1F, 5);
    run_sweep(8'hFF, -1);
    for (int k = 0; k < 2; k++)
      run_sweep(8'($urandom), -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
